// File: rtl/alu_nibble_seq.sv
// Multi-cycle COMET2 add/subtract unit: one 4-bit adder slice reused over WIDTH/4 cycles,
// least significant nibble first, producing the result and {OF,SF,ZF}.
module alu_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int unsigned   NumNib  = WIDTH / 4;
    localparam int unsigned   IdxW    = (NumNib > 1) ? $clog2(NumNib) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;

    logic [3:0]       a_nib, b_nib;
    logic [4:0]       sum;
    logic [WIDTH-1:0] res_nxt;
    logic             of_nxt;

    // Shared nibble slice: select the current nibble and merge its sum into the working value.
    always_comb begin
        a_nib   = 4'h0;
        b_nib   = 4'h0;
        for (int unsigned i = 0; i < NumNib; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
        sum     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        res_nxt = work_q;
        for (int unsigned i = 0; i < NumNib; i++) begin
            if (idx_q == IdxW'(i)) begin
                res_nxt[i*4 +: 4] = sum[3:0];
            end
        end
    end

    // b_q already holds ~b for subtraction, so signed overflow has the same form for ADDA/SUBA.
    always_comb begin
        unique case (op_q)
            2'b01:   of_nxt = sum[4];
            2'b11:   of_nxt = ~sum[4];
            default: of_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = op[1] ? ~b : b;
                    op_d    = op;
                    carry_d = op[1];
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                work_d  = res_nxt;
                carry_d = sum[4];
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    idx_d    = '0;
                    result_d = res_nxt;
                    flags_d  = {of_nxt, res_nxt[WIDTH-1], (res_nxt == '0)};
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            flags_q  <= 3'b000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q == StCalc) || (state_q == StDone);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq: a cycle-level reference model plus hand-computed results.
module tb_alu_nibble_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  flags;

    alu_nibble_seq #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 17-bit arithmetic, flags from the COMET2 definitions.
    function automatic logic [18:0] model_op(input logic [1:0] o, input logic [15:0] x,
                                             input logic [15:0] y);
        logic [16:0] full;
        logic [15:0] r;
        logic        of;
        full = o[1] ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r    = full[15:0];
        case (o)
            2'b00:   of = (x[15] == y[15]) && (r[15] != x[15]);
            2'b01:   of = full[16];
            2'b10:   of = (x[15] != y[15]) && (r[15] != x[15]);
            default: of = (x < y);
        endcase
        return {r, of, r[15], (r == 16'h0000)};
    endfunction

    // Timing model: an operation accepted at edge N is done after edge N+4 and idle after N+5.
    int          cyc;
    int          acc;
    logic        m_active;
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_res;
    logic [2:0]  m_flg;
    logic [18:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= 0;
            acc      <= 0;
            m_active <= 1'b0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_res    <= 16'h0000;
            m_flg    <= 3'b000;
            m_pend   <= '0;
        end else begin
            cyc <= cyc + 1;
            if ((!m_active || (cyc - acc) >= 5) && start) begin
                acc      <= cyc + 1;
                m_active <= 1'b1;
                m_pend   <= model_op(op, a, b);
                m_busy   <= 1'b1;
                m_done   <= 1'b0;
            end else if (m_active) begin
                m_busy <= (cyc + 1 - acc) < 5;
                m_done <= (cyc + 1 - acc) == 4;
                if ((cyc + 1 - acc) == 4) begin
                    m_res <= m_pend[18:3];
                    m_flg <= m_pend[2:0];
                end
            end else begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    // Literal checks are posted by the stimulus and evaluated here, so one process owns the counts.
    int    vectors;
    int    miscompares;
    int    nedge;
    int    busy_total;
    int    done_total;
    int    lit_seq;
    int    lit_seen;
    int    lit_kind;
    int    lit_act;
    int    lit_exp;
    string lit_name;

    initial begin
        vectors     = 0;
        miscompares = 0;
        nedge       = 0;
        busy_total  = 0;
        done_total  = 0;
        lit_seen    = 0;
    end

    always @(negedge clk) begin
        nedge = nedge + 1;
        if (busy === 1'b1) busy_total = busy_total + 1;
        if (done === 1'b1) done_total = done_total + 1;
        if (rst_n === 1'b1) begin
            vectors = vectors + 1;
            if (busy !== m_busy || done !== m_done || result !== m_res || flags !== m_flg) begin
                miscompares = miscompares + 1;
                $display("FAIL model cyc=%0d: got busy=%b done=%b result=%h flags=%b, want busy=%b done=%b result=%h flags=%b",
                         nedge, busy, done, result, flags, m_busy, m_done, m_res, m_flg);
            end
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            vectors  = vectors + 1;
            if (lit_kind == 0) begin
                if ({result, flags} !== lit_exp[18:0]) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
                             lit_name, result, flags, lit_exp[18:3], lit_exp[2:0]);
                end
            end else if (lit_kind == 1) begin
                if ({busy, done, result, flags} !== 21'd0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s: got busy=%b done=%b result=%h flags=%b, want all zero",
                             lit_name, busy, done, result, flags);
                end
            end else begin
                if (lit_act != lit_exp) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s: got %0d, want %0d", lit_name, lit_act, lit_exp);
                end
            end
        end
    end

    task automatic post(input int kind, input string nm, input int act, input int exp_v);
        lit_kind = kind;
        lit_name = nm;
        lit_act  = act;
        lit_exp  = exp_v;
        lit_seq  = lit_seq + 1;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        if (!seen) post(2, {nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic [2:0] ef, input string nm);
        int b0;
        int d0;
        @(posedge clk);
        #2;
        b0    = busy_total;
        d0    = done_total;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        op    = 2'($urandom);
        wait_done(nm);
        post(0, nm, 0, int'({er, ef}));
        repeat (2) @(negedge clk);
        #1;
        post(2, {nm, "_busy_cycles"}, busy_total - b0, 5);
        post(2, {nm, "_done_pulses"}, done_total - d0, 1);
    endtask

    initial begin
        int d0;
        int t1;
        int t2;
        int t3;
        lit_seq = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = 16'h0000;
        b       = 16'h0000;
        #1;
        post(1, "reset_state", 0, 0);
        rst_n = 1'b1;

        run_op(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, "adda_ovf");
        run_op(2'b01, 16'hFFFF, 16'h0001, 16'h0000, 3'b101, "addl_carry");
        run_op(2'b01, 16'h1234, 16'h4321, 16'h5555, 3'b000, "addl_plain");
        run_op(2'b11, 16'h0000, 16'h0001, 16'hFFFF, 3'b110, "subl_borrow");
        run_op(2'b10, 16'h8000, 16'h0001, 16'h7FFF, 3'b100, "suba_ovf");

        // Abort during the second CALC cycle; outputs must clear without waiting for a clock.
        @(posedge clk);
        #2;
        d0    = done_total;
        start = 1'b1;
        op    = 2'b00;
        a     = 16'h1111;
        b     = 16'h2222;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        post(1, "reset_midop", 0, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        post(2, "reset_no_done", done_total - d0, 0);

        run_op(2'b00, 16'h0010, 16'h0020, 16'h0030, 3'b000, "adda_after_reset");
        run_op(2'b10, 16'h0005, 16'h0005, 16'h0000, 3'b001, "suba_zero");

        // Second start two cycles into an operation must be ignored.
        @(posedge clk);
        #2;
        d0    = done_total;
        start = 1'b1;
        op    = 2'b01;
        a     = 16'h0001;
        b     = 16'h0001;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(posedge clk);
        #2;
        start = 1'b0;
        a     = 16'h1234;
        b     = 16'h5678;
        op    = 2'b10;
        wait_done("busy_start");
        post(0, "busy_start", 0, int'({16'h0002, 3'b000}));
        repeat (6) @(negedge clk);
        #1;
        post(2, "busy_start_done_pulses", done_total - d0, 1);

        // start held high across three operations.
        @(posedge clk);
        #2;
        start = 1'b1;
        op    = 2'b01;
        a     = 16'h0001;
        b     = 16'h0002;
        wait_done("b2b_1");
        t1 = nedge;
        post(0, "b2b_1", 0, int'({16'h0003, 3'b000}));
        op = 2'b11;
        a  = 16'h0003;
        b  = 16'h0005;
        wait_done("b2b_2");
        t2 = nedge;
        post(0, "b2b_2", 0, int'({16'hFFFE, 3'b110}));
        op = 2'b00;
        a  = 16'h0F0F;
        b  = 16'h00F1;
        wait_done("b2b_3");
        t3    = nedge;
        start = 1'b0;
        post(0, "b2b_3", 0, int'({16'h1000, 3'b000}));
        post(2, "b2b_spacing_1", t2 - t1, 6);
        post(2, "b2b_spacing_2", t3 - t2, 6);
        repeat (4) @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
